pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Run controller for the program counter. Owns the PC's synchronous init, gates
//  decoder branch/jump requests into the PC's branch_en/jump_en, and detects
//  program completion from the PC's halt flag.
//  Runs a watchdog that aborts runaway programs. Sits between top-level
//  start/status and the PC + decoder.
// PARAMETERS
//  INIT_CYCLES  2     cycles pc_init is held high after start (>=1)
//  CNT_W        16    width of run-cycle counter and perf counters
//  MAX_CYCLES   1023  watchdog limit in RUN cycles; 0 = watchdog disabled
// PORTS
//  CLK          in   1      clock, all state on posedge
//  init_n       in   1      asynchronous active-low reset
//  start        in   1      level; begin (or restart) a program run
//  branch_req   in   1      decoder requests taken branch this cycle
//  jump_req     in   1      decoder requests jump this cycle
//  pc_halt      in   1      halt output of the PC
//  pc_init      out  1      drives PC init (sync, active-high)
//  pc_branch_en out  1      drives PC branch_en
//  pc_jump_en   out  1      drives PC jump_en
//  busy         out  1      1 in INIT or RUN
//  done         out  1      1 in DONE (normal completion)
//  fault        out  1      1 in FAULT (watchdog expiry)
//  run_cycles   out  CNT_W  RUN cycles of current/last run; saturates at all-ones
// BEHAVIOUR
//  - Async reset (init_n=0): state=IDLE, init counter=0, run_cycles=0,
//    perf counters=0. Outputs: pc_init=1, pc_branch_en=0, pc_jump_en=0,
//    busy=0, done=0, fault=0. Reset mid-run aborts immediately; no state survives.
//  - States: IDLE, INIT, RUN, DONE, FAULT. State and counters are registered.
//    pc_* enables are combinational from state and request inputs.
//  - IDLE: pc_init=1. start=1 -> INIT. Init counter loads 0 and run_cycles clears.
//  - INIT: pc_init=1, busy=1. Count INIT_CYCLES cycles, then -> RUN.
//    start is ignored while in INIT.
//  - RUN: pc_init=0, busy=1. Per cycle:
//    pc_branch_en = branch_req & ~pc_halt.
//    pc_jump_en = jump_req & ~branch_req & ~pc_halt (branch wins on a
//    simultaneous request; at most one enable is ever high).
//    run_cycles increments by 1 each RUN cycle and saturates at 2^CNT_W-1.
//    pc_halt=1 -> DONE next cycle; requests in the halt cycle are dropped.
//    Watchdog: if MAX_CYCLES!=0 and run_cycles==MAX_CYCLES-1 in a RUN cycle
//    with pc_halt=0 -> FAULT. pc_halt in the same cycle takes priority
//    (-> DONE). start in RUN is ignored.
//  - DONE: done=1, pc_init=0 (PC holds its halted state), enables 0,
//    run_cycles frozen. start=1 -> INIT.
//  - FAULT: fault=1, pc_init=1 (PC forced to 0), enables 0, run_cycles
//    frozen. start=1 -> INIT.
//  - Branch/jump requests outside RUN are ignored. pc_halt outside RUN is ignored.
//  - done/fault are level flags that clear on the transition to INIT.
// CONFIGURATION
//  Macro SEQ_PERF_CNT_EN:
//   Defined: adds outputs branch_cnt and jump_cnt (CNT_W each). They count
//   pc_branch_en and pc_jump_en cycles in RUN, saturate, clear on entry to
//   INIT and on reset, and freeze in DONE/FAULT.
//   Undefined: the ports and counters are absent. All other behaviour is
//   identical.
// TESTING
//  1 Reset: init_n=0 with random inputs -> pc_init=1, enables=0, busy=done=fault=0, run_cycles=0.
//  2 Start: start=1 for 1 cycle from IDLE, INIT_CYCLES=2 -> pc_init high 2 more cycles, then RUN with busy=1, pc_init=0.
//  3 Arbitration: in RUN, branch_req=jump_req=1 -> pc_branch_en=1, pc_jump_en=0. jump_req only -> pc_jump_en=1. pc_halt=1 with branch_req=1 -> both 0.
//  4 Completion: pc_halt rises after 40 RUN cycles -> DONE next cycle, done=1, run_cycles=40 and holds; start -> INIT, done=0, run_cycles=0.
//  5 Watchdog: MAX_CYCLES=8, no pc_halt -> FAULT after the 8th RUN cycle, fault=1, pc_init=1. Repeat with pc_halt in the 8th cycle -> DONE, not FAULT.
//  6 Abort and perf: init_n pulsed low mid-RUN -> IDLE outputs at once. With SEQ_PERF_CNT_EN, 3 branches + 2 jumps (one simultaneous) -> branch_cnt=3, jump_cnt=1.

Source files
------------

// File: rtl/pc_sequencer.sv
// Run controller for the program counter: PC init, branch/jump gating, halt detection and watchdog abort.
// Optional branch/jump performance counters are built only when SEQ_PERF_CNT_EN is defined.
module pc_sequencer #(
   parameter int unsigned INIT_CYCLES = 2,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned MAX_CYCLES  = 1023
) (
   input  logic             CLK,
   input  logic             init_n,
   input  logic             start,
   input  logic             branch_req,
   input  logic             jump_req,
   input  logic             pc_halt,
   output logic             pc_init,
   output logic             pc_branch_en,
   output logic             pc_jump_en,
   output logic             busy,
   output logic             done,
   output logic             fault,
   output logic [CNT_W-1:0] run_cycles
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] jump_cnt
`endif
);

   localparam int unsigned      INIT_W    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
   localparam bit               WD_EN     = (MAX_CYCLES != 0);
   localparam logic [CNT_W-1:0] WD_LAST   = WD_EN ? CNT_W'(MAX_CYCLES - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_RUN,
      S_DONE,
      S_FAULT
   } state_t;

   state_t              state_q, state_d;
   logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
   logic [CNT_W-1:0]    run_cycles_q, run_cycles_d;
   logic                enter_init;
   logic                in_run;

   // A new run can only be launched from a resting state; INIT and RUN ignore start.
   assign enter_init = start &&
                       ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAULT));
   assign in_run     = (state_q == S_RUN);

   always_comb begin
      state_d      = state_q;
      init_cnt_d   = init_cnt_q;
      run_cycles_d = run_cycles_q;
      if (enter_init) begin
         state_d      = S_INIT;
         init_cnt_d   = '0;
         run_cycles_d = '0;
      end else begin
         case (state_q)
            S_INIT: begin
               if (init_cnt_q == INIT_LAST) begin
                  state_d = S_RUN;
               end else begin
                  init_cnt_d = init_cnt_q + INIT_W'(1);
               end
            end
            S_RUN: begin
               if (run_cycles_q != '1) begin
                  run_cycles_d = run_cycles_q + CNT_ONE;
               end
               // Halt wins over a watchdog expiry landing in the same cycle.
               if (pc_halt) begin
                  state_d = S_DONE;
               end else if (WD_EN && (run_cycles_q == WD_LAST)) begin
                  state_d = S_FAULT;
               end
            end
            S_IDLE, S_DONE, S_FAULT: begin
               state_d = state_q;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge init_n) begin
      if (!init_n) begin
         state_q      <= S_IDLE;
         init_cnt_q   <= '0;
         run_cycles_q <= '0;
      end else begin
         state_q      <= state_d;
         init_cnt_q   <= init_cnt_d;
         run_cycles_q <= run_cycles_d;
      end
   end

   // FAULT keeps the PC in init so it sits at 0; DONE releases it to hold the halted PC.
   assign pc_init      = (state_q == S_IDLE) || (state_q == S_INIT) || (state_q == S_FAULT);
   assign pc_branch_en = in_run & branch_req & ~pc_halt;
   assign pc_jump_en   = in_run & jump_req & ~branch_req & ~pc_halt;
   assign busy         = (state_q == S_INIT) || in_run;
   assign done         = (state_q == S_DONE);
   assign fault        = (state_q == S_FAULT);
   assign run_cycles   = run_cycles_q;

`ifdef SEQ_PERF_CNT_EN
   logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0] jump_cnt_q, jump_cnt_d;

   always_comb begin
      branch_cnt_d = branch_cnt_q;
      jump_cnt_d   = jump_cnt_q;
      if (enter_init) begin
         branch_cnt_d = '0;
         jump_cnt_d   = '0;
      end else if (in_run) begin
         if (pc_branch_en && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + CNT_ONE;
         end
         if (pc_jump_en && (jump_cnt_q != '1)) begin
            jump_cnt_d = jump_cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge CLK or negedge init_n) begin
      if (!init_n) begin
         branch_cnt_q <= '0;
         jump_cnt_q   <= '0;
      end else begin
         branch_cnt_q <= branch_cnt_d;
         jump_cnt_q   <= jump_cnt_d;
      end
   end

   assign branch_cnt = branch_cnt_q;
   assign jump_cnt   = jump_cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: default instance, an 8-cycle watchdog instance and a 4-bit no-watchdog instance.
module tb_pc_sequencer;

   logic CLK = 1'b0;
   logic init_n, start, branch_req, jump_req, pc_halt;

   logic d_pc_init, d_br, d_jmp, d_busy, d_done, d_fault;
   logic w_pc_init, w_br, w_jmp, w_busy, w_done, w_fault;
   logic s_pc_init, s_br, s_jmp, s_busy, s_done, s_fault;
   logic [15:0] d_run, w_run;
   logic [3:0]  s_run;
`ifdef SEQ_PERF_CNT_EN
   logic [15:0] d_bcnt, d_jcnt, w_bcnt, w_jcnt;
   logic [3:0]  s_bcnt, s_jcnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   pc_sequencer u_dut (
      .CLK(CLK), .init_n(init_n), .start(start), .branch_req(branch_req),
      .jump_req(jump_req), .pc_halt(pc_halt), .pc_init(d_pc_init),
      .pc_branch_en(d_br), .pc_jump_en(d_jmp), .busy(d_busy), .done(d_done),
      .fault(d_fault), .run_cycles(d_run)
`ifdef SEQ_PERF_CNT_EN
      , .branch_cnt(d_bcnt), .jump_cnt(d_jcnt)
`endif
   );

   pc_sequencer #(.MAX_CYCLES(8)) u_wd (
      .CLK(CLK), .init_n(init_n), .start(start), .branch_req(branch_req),
      .jump_req(jump_req), .pc_halt(pc_halt), .pc_init(w_pc_init),
      .pc_branch_en(w_br), .pc_jump_en(w_jmp), .busy(w_busy), .done(w_done),
      .fault(w_fault), .run_cycles(w_run)
`ifdef SEQ_PERF_CNT_EN
      , .branch_cnt(w_bcnt), .jump_cnt(w_jcnt)
`endif
   );

   pc_sequencer #(.CNT_W(4), .MAX_CYCLES(0)) u_sat (
      .CLK(CLK), .init_n(init_n), .start(start), .branch_req(branch_req),
      .jump_req(jump_req), .pc_halt(pc_halt), .pc_init(s_pc_init),
      .pc_branch_en(s_br), .pc_jump_en(s_jmp), .busy(s_busy), .done(s_done),
      .fault(s_fault), .run_cycles(s_run)
`ifdef SEQ_PERF_CNT_EN
      , .branch_cnt(s_bcnt), .jump_cnt(s_jcnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not reach its summary");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset with random inputs
      init_n = 1'b1; start = 1'b0; branch_req = 1'b0; jump_req = 1'b0; pc_halt = 1'b0;
      #1;
      init_n     = 1'b0;
      start      = 1'($urandom_range(0, 1));
      branch_req = 1'($urandom_range(0, 1));
      jump_req   = 1'($urandom_range(0, 1));
      pc_halt    = 1'($urandom_range(0, 1));
      #1;
      chk("rst_pc_init", d_pc_init, 1);
      chk("rst_br_en",   d_br, 0);
      chk("rst_jmp_en",  d_jmp, 0);
      chk("rst_busy",    d_busy, 0);
      chk("rst_done",    d_done, 0);
      chk("rst_fault",   d_fault, 0);
      chk("rst_run",     d_run, 0);
      tick();
      chk("rst_hold_busy", d_busy, 0);
      chk("rst_hold_init", d_pc_init, 1);
      init_n = 1'b1; start = 1'b0; branch_req = 1'b0; jump_req = 1'b0; pc_halt = 1'b0;
      tick(2);
      chk("idle_pc_init", d_pc_init, 1);
      chk("idle_busy",    d_busy, 0);

      // Start: INIT lasts two cycles
      start = 1'b1;
      #1;
      chk("start_idle_busy", d_busy, 0);
      tick();
      start = 1'b0;
      chk("init1_pc_init", d_pc_init, 1);
      chk("init1_busy",    d_busy, 1);
      tick();
      chk("init2_pc_init", d_pc_init, 1);
      chk("init2_busy",    d_busy, 1);
      tick();
      chk("run_pc_init", d_pc_init, 0);
      chk("run_busy",    d_busy, 1);
      chk("run_cycles0", d_run, 0);

      // Arbitration inside the first RUN cycle
      branch_req = 1'b1; jump_req = 1'b1;
      #1;
      chk("arb_both_br",  d_br, 1);
      chk("arb_both_jmp", d_jmp, 0);
      branch_req = 1'b0;
      #1;
      chk("arb_jmp_br",  d_br, 0);
      chk("arb_jmp_jmp", d_jmp, 1);
      branch_req = 1'b1; pc_halt = 1'b1;
      #1;
      chk("arb_halt_br",  d_br, 0);
      chk("arb_halt_jmp", d_jmp, 0);
      branch_req = 1'b0; jump_req = 1'b0; pc_halt = 1'b0;

      // Completion: halt in the 40th RUN cycle
      tick(39);
      chk("c40_run", d_run, 39);
      pc_halt = 1'b1;
      #1;
      chk("c40_done_pre", d_done, 0);
      tick();
      pc_halt = 1'b0; branch_req = 1'b1;
      #1;
      chk("done_flag",    d_done, 1);
      chk("done_busy",    d_busy, 0);
      chk("done_pc_init", d_pc_init, 0);
      chk("done_run",     d_run, 40);
      chk("done_br_en",   d_br, 0);
      chk("sat_run",      s_run, 15);
      chk("sat_done",     s_done, 1);
      chk("wd_fault_bg",  w_fault, 1);
      chk("wd_run_bg",    w_run, 8);
      branch_req = 1'b0; pc_halt = 1'b1;
      tick(3);
      pc_halt = 1'b0;
      chk("done_hold_run",  d_run, 40);
      chk("done_hold_flag", d_done, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_done",    d_done, 0);
      chk("restart_run",     d_run, 0);
      chk("restart_busy",    d_busy, 1);
      chk("restart_pc_init", d_pc_init, 1);
      chk("restart_wd_flt",  w_fault, 0);

      // Watchdog with MAX_CYCLES=8; start in RUN is ignored
      tick(2);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("run_start_ign", d_pc_init, 0);
      chk("run_start_cnt", d_run, 1);
      tick(6);
      chk("wd_c8_fault", w_fault, 0);
      chk("wd_c8_busy",  w_busy, 1);
      chk("wd_c8_run",   w_run, 7);
      tick();
      branch_req = 1'b1;
      #1;
      chk("wd_fault",     w_fault, 1);
      chk("wd_pc_init",   w_pc_init, 1);
      chk("wd_busy",      w_busy, 0);
      chk("wd_run",       w_run, 8);
      chk("wd_br_en",     w_br, 0);
      chk("dflt_no_wd",   d_busy, 1);
      branch_req = 1'b0; pc_halt = 1'b1;
      tick();
      pc_halt = 1'b0;
      tick();
      chk("wd_hold_run",   w_run, 8);
      chk("wd_hold_fault", w_fault, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(2);
      tick(7);
      chk("wd2_c8_busy", w_busy, 1);
      pc_halt = 1'b1;
      tick();
      pc_halt = 1'b0;
      chk("wd2_done",  w_done, 1);
      chk("wd2_fault", w_fault, 0);
      chk("wd2_run",   w_run, 8);

      // Perf counters, then asynchronous abort mid-RUN
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(2);
      branch_req = 1'b1;
      tick(2);
      jump_req = 1'b1;
      tick();
      branch_req = 1'b0;
      tick();
      jump_req = 1'b0;
      chk("perf_run",  d_run, 4);
      chk("perf_busy", d_busy, 1);
`ifdef SEQ_PERF_CNT_EN
      chk("perf_branch_cnt", d_bcnt, 3);
      chk("perf_jump_cnt",   d_jcnt, 1);
`endif
      init_n = 1'b0; branch_req = 1'b1;
      #1;
      chk("abort_pc_init", d_pc_init, 1);
      chk("abort_busy",    d_busy, 0);
      chk("abort_run",     d_run, 0);
      chk("abort_br_en",   d_br, 0);
      chk("abort_done",    d_done, 0);
      chk("abort_wd_busy", w_busy, 0);
`ifdef SEQ_PERF_CNT_EN
      chk("abort_branch_cnt", d_bcnt, 0);
      chk("abort_jump_cnt",   d_jcnt, 0);
`endif
      branch_req = 1'b0;
      #1;
      init_n = 1'b1;
      tick();
      chk("post_abort_busy", d_busy, 0);
      chk("post_abort_init", d_pc_init, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
